round_sequencer: RTL and testbench
==================================

ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter WAIT_BASE, default 1000: minimum cycles in WAIT before LEDs arm.
REQ-002 Parameter HOLD_CYCLES, default 500: cycles the round result is displayed in HOLD.
REQ-003 Parameter LFSR_SEED, default 8'hA5: nonzero reset value of the random-delay LFSR.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 pbl  input  1  left button, synchronized single-cycle pulse.
REQ-007 pbr  input  1  right button, synchronized single-cycle pulse.
REQ-008 score  input  7  one-hot rope position from scorer; centre 7'b0001000.
REQ-009 clr  output  1  one-cycle clear pulse to scorer/button logic.
REQ-010 leds_on  output  1  high while ARMED (players may pull).
REQ-011 winrnd  output  1  one-cycle pulse: round won.
REQ-012 right  output  1  valid with winrnd: 1 = right player won, 0 = left.
REQ-013 tie  output  1  one-cycle pulse: simultaneous press in ARMED.
REQ-014 led_control  output  2  LED mux select: 00 blank, 01 score, 10 all-on, 11 winner.
REQ-015 gameover  output  1  high while in GAMEOVER.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, ARMED, RESOLVE, HOLD, GAMEOVER.
REQ-017 IDLE: clr=1 for exactly one cycle, load delay counter with WAIT_BASE + LFSR[7:0], go to WAIT.
REQ-018 WAIT: led_control=01, counter decrements each cycle; at zero go to ARMED next cycle.
REQ-019 ARMED: leds_on=1, led_control=10; exactly one of pbl/pbr in a cycle -> RESOLVE, latching right=pbr.
REQ-020 ARMED with pbl and pbr in the same cycle: tie=1 for that next cycle, no winrnd, go to IDLE.
REQ-021 RESOLVE: winrnd=1 for exactly one cycle with latched right, then HOLD loaded with HOLD_CYCLES.
REQ-022 HOLD: led_control=01, presses ignored; on count expiry go to GAMEOVER if score[0] or score[6] set, else IDLE.
REQ-023 GAMEOVER: led_control=11, gameover=1; first press on either button -> IDLE (which issues clr).
REQ-024 LFSR: 8-bit maximal-length, x^8+x^6+x^5+x^4+1, advances every cycle, never zero.
REQ-025 Delay counter SHALL be 17 bits; WAIT_BASE+255 SHALL not overflow it.
REQ-026 All outputs registered; winrnd/tie/clr never high in the same cycle.

Reset
REQ-027 rst asserted SHALL immediately force state IDLE, counters 0, LFSR=LFSR_SEED, latched right=0.
REQ-028 During rst: clr=0, leds_on=0, winrnd=0, right=0, tie=0, gameover=0, led_control=00.
REQ-029 Reset mid-round SHALL discard any pending result; first cycle after release is IDLE.

Configuration
REQ-030 Macro TOW_FALSE_START_EN: when defined, a single press in WAIT goes to RESOLVE with the opponent as winner (right = pbl); both pressed in WAIT -> tie, IDLE.
REQ-031 Without TOW_FALSE_START_EN, presses in WAIT SHALL be ignored and WAIT runs to completion.

Structure
REQ-032 Shared package tow_pkg SHALL hold the state enum and the four led_control encodings.
REQ-033 LFSR SHALL be a sub-module tow_lfsr (seed parameter, enable, 8-bit output).

Verification
REQ-034 Reset release, WAIT_BASE=4, seed A5 -> clr pulse cycle 1, leds_on rises after 4+A5 WAIT cycles.
REQ-035 pbr alone in ARMED -> winrnd=1, right=1 exactly one cycle, then HOLD_CYCLES of led_control=01.
REQ-036 pbl and pbr same cycle in ARMED -> tie=1 one cycle, winrnd stays 0, clr pulse follows.
REQ-037 score=7'b1000000 at HOLD expiry -> gameover=1, led_control=11; pbl pulse -> IDLE, clr=1.
REQ-038 pbl in WAIT with TOW_FALSE_START_EN -> winrnd=1, right=1; without macro -> no output change.
REQ-039 rst asserted in ARMED mid-cycle -> all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war round sequencer: FSM state type,
// LED mux select encodings, delay-counter width and the LFSR step function.
package tow_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ARMED,
        ST_RESOLVE,
        ST_HOLD,
        ST_GAMEOVER
    } state_t;

    // LED mux select values driven on led_control
    localparam logic [1:0] LED_BLANK  = 2'b00;
    localparam logic [1:0] LED_SCORE  = 2'b01;
    localparam logic [1:0] LED_ALL    = 2'b10;
    localparam logic [1:0] LED_WINNER = 2'b11;

    // 17 bits holds WAIT_BASE + 255 for any WAIT_BASE below 130817
    localparam int CNT_W = 17;

    // Rope positions that end the game (either outermost LED)
    localparam logic [6:0] END_MASK = 7'b1000001;

    // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3)
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] value);
        return {value[6:0], ^(value & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tow_lfsr.sv
// 8-bit maximal-length Fibonacci LFSR used to randomise the pre-arm delay.
// A zero seed would lock the register up, so it is replaced by 8'h01.
module tow_lfsr
    import tow_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] value
);

    localparam logic [7:0] SEED_SAFE = (SEED == 8'h00) ? 8'h01 : SEED;

    logic [7:0] lfsr_reg;

    // Shift register: reseed on reset, otherwise step whenever enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= SEED_SAFE;
        end else if (en) begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    assign value = lfsr_reg;

endmodule

// File: rtl/round_sequencer.sv
// Round sequencer for the tug-of-war game: random pre-arm delay, arming,
// winner/tie resolution, result hold and game-over handling.
// Optional build macro TOW_FALSE_START_EN: a press during WAIT is a false
// start and hands the round to the opponent (both pressed -> tie).
//
// Output timing: leds_on, led_control, gameover, winrnd and right follow the
// state they belong to (registered from the next state). tie is high in the
// IDLE cycle that follows a simultaneous press, and clr is high in the cycle
// after IDLE, so a reset release also produces a clr pulse. The three pulses
// therefore live in different states and can never overlap.
module round_sequencer
    import tow_pkg::*;
#(
    parameter int         WAIT_BASE   = 1000,
    parameter int         HOLD_CYCLES = 500,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pbl,
    input  logic       pbr,
    input  logic [6:0] score,
    output logic       clr,
    output logic       leds_on,
    output logic       winrnd,
    output logic       right,
    output logic       tie,
    output logic [1:0] led_control,
    output logic       gameover
);

    localparam logic [CNT_W-1:0] WAIT_BASE_C = CNT_W'(WAIT_BASE);
    localparam logic [CNT_W-1:0] HOLD_C      = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             right_latch_reg, right_latch_next;
    logic             tie_next;
    logic [1:0]       led_next;
    logic [7:0]       lfsr_value;
    logic             press_one;
    logic             press_both;
    logic             at_end;

    logic       clr_reg;
    logic       leds_on_reg;
    logic       winrnd_reg;
    logic       right_reg;
    logic       tie_reg;
    logic [1:0] led_control_reg;
    logic       gameover_reg;

    tow_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .value (lfsr_value)
    );

    assign press_one  = pbl ^ pbr;
    assign press_both = pbl & pbr;
    assign at_end     = |(score & END_MASK);

    // Next-state logic; counts of N run for exactly N cycles in WAIT/HOLD
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        right_latch_next = right_latch_reg;
        tie_next         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next   = WAIT_BASE_C + {{(CNT_W-8){1'b0}}, lfsr_value};
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_reg <= CNT_ONE) begin
                    state_next = ST_ARMED;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
`ifdef TOW_FALSE_START_EN
                // Pressing before the LEDs arm forfeits the round
                if (press_both) begin
                    tie_next   = 1'b1;
                    state_next = ST_IDLE;
                end else if (press_one) begin
                    right_latch_next = pbl;
                    state_next       = ST_RESOLVE;
                end
`endif
            end
            ST_ARMED: begin
                if (press_both) begin
                    tie_next   = 1'b1;
                    state_next = ST_IDLE;
                end else if (press_one) begin
                    right_latch_next = pbr;
                    state_next       = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                cnt_next   = HOLD_C;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_reg <= CNT_ONE) begin
                    state_next = at_end ? ST_GAMEOVER : ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_GAMEOVER: begin
                if (pbl || pbr) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // LED mux select for the state being entered
    always_comb begin
        led_next = LED_BLANK;
        case (state_next)
            ST_WAIT, ST_RESOLVE, ST_HOLD: led_next = LED_SCORE;
            ST_ARMED:                     led_next = LED_ALL;
            ST_GAMEOVER:                  led_next = LED_WINNER;
            default:                      led_next = LED_BLANK;
        endcase
    end

    // State, delay counter and latched winner side
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            right_latch_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            right_latch_reg <= right_latch_next;
        end
    end

    // Registered outputs, all forced low while reset is asserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_reg         <= 1'b0;
            leds_on_reg     <= 1'b0;
            winrnd_reg      <= 1'b0;
            right_reg       <= 1'b0;
            tie_reg         <= 1'b0;
            led_control_reg <= LED_BLANK;
            gameover_reg    <= 1'b0;
        end else begin
            clr_reg         <= (state_reg == ST_IDLE);
            leds_on_reg     <= (state_next == ST_ARMED);
            winrnd_reg      <= (state_next == ST_RESOLVE);
            right_reg       <= (state_next == ST_RESOLVE) && right_latch_next;
            tie_reg         <= tie_next;
            led_control_reg <= led_next;
            gameover_reg    <= (state_next == ST_GAMEOVER);
        end
    end

    assign clr         = clr_reg;
    assign leds_on     = leds_on_reg;
    assign winrnd      = winrnd_reg;
    assign right       = right_reg;
    assign tie         = tie_reg;
    assign led_control = led_control_reg;
    assign gameover    = gameover_reg;

endmodule

// File: tb/tb_round_sequencer.sv
// Testbench for round_sequencer: directed rounds with hand-computed timing,
// plus a deadline-based reference model compared against the DUT every cycle.
module tb_round_sequencer;

    localparam int         TB_WAIT_BASE = 4;
    localparam int         TB_HOLD      = 6;
    localparam logic [7:0] TB_SEED      = 8'hA5;
    localparam logic [6:0] CENTRE       = 7'b0001000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pbl = 1'b0;
    logic       pbr = 1'b0;
    logic [6:0] score = CENTRE;
    logic       clr, leds_on, winrnd, right, tie, gameover;
    logic [1:0] led_control;
    logic [7:0] dut_vec;

    int n_checks = 0;
    int n_errors = 0;

    round_sequencer #(
        .WAIT_BASE   (TB_WAIT_BASE),
        .HOLD_CYCLES (TB_HOLD),
        .LFSR_SEED   (TB_SEED)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pbl         (pbl),
        .pbr         (pbr),
        .score       (score),
        .clr         (clr),
        .leds_on     (leds_on),
        .winrnd      (winrnd),
        .right       (right),
        .tie         (tie),
        .led_control (led_control),
        .gameover    (gameover)
    );

    always #5 clk = ~clk;

    assign dut_vec = {clr, leds_on, winrnd, right, tie, led_control, gameover};

    // ---------------- reference model ----------------
    // Phases are tracked with absolute deadlines (cycle numbers) rather than
    // down-counters: a wait of N cycles entered at cycle c ends after c+N-1.
    localparam int P_IDLE = 0, P_WAIT = 1, P_ARMED = 2, P_RESOLVE = 3, P_HOLD = 4, P_OVER = 5;

    int         m_cyc = 0;
    int         m_phase = P_IDLE;
    int         m_prev = P_IDLE;
    int         m_end = 0;
    logic [7:0] m_lfsr = TB_SEED;
    logic       e_clr = 0, e_leds = 0, e_win = 0, e_right = 0, e_tie = 0, e_over = 0;
    logic [1:0] e_ledc = 2'b00;
    logic [7:0] exp_vec;

    assign exp_vec = {e_clr, e_leds, e_win, e_right, e_tie, e_ledc, e_over};

    function automatic logic [7:0] model_lfsr_next(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cyc = 0; m_phase = P_IDLE; m_end = 0; m_lfsr = TB_SEED;
                e_clr = 0; e_leds = 0; e_win = 0; e_right = 0; e_tie = 0; e_over = 0;
                e_ledc = 2'b00;
            end else begin
                m_prev = m_phase;
                m_cyc++;
                e_clr = (m_prev == P_IDLE);
                e_win = 0; e_right = 0; e_tie = 0;
                case (m_prev)
                    P_IDLE: begin
                        m_end   = m_cyc + TB_WAIT_BASE + int'(m_lfsr) - 1;
                        m_phase = P_WAIT;
                    end
                    P_WAIT: begin
`ifdef TOW_FALSE_START_EN
                        if (pbl && pbr) begin
                            e_tie = 1; m_phase = P_IDLE;
                        end else if (pbl || pbr) begin
                            e_win = 1; e_right = pbl; m_phase = P_RESOLVE;
                        end else
`endif
                        if (m_cyc > m_end) m_phase = P_ARMED;
                    end
                    P_ARMED: begin
                        if (pbl && pbr) begin
                            e_tie = 1; m_phase = P_IDLE;
                        end else if (pbl || pbr) begin
                            e_win = 1; e_right = pbr; m_phase = P_RESOLVE;
                        end
                    end
                    P_RESOLVE: begin
                        m_end   = m_cyc + TB_HOLD - 1;
                        m_phase = P_HOLD;
                    end
                    P_HOLD: begin
                        if (m_cyc > m_end) m_phase = (score[0] || score[6]) ? P_OVER : P_IDLE;
                    end
                    default: begin
                        if (pbl || pbr) m_phase = P_IDLE;
                    end
                endcase
                m_lfsr = model_lfsr_next(m_lfsr);
                e_leds = (m_phase == P_ARMED);
                e_over = (m_phase == P_OVER);
                case (m_phase)
                    P_ARMED: e_ledc = 2'b10;
                    P_OVER:  e_ledc = 2'b11;
                    P_IDLE:  e_ledc = 2'b00;
                    default: e_ledc = 2'b01;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL cycle_compare t=%0t got {clr,leds_on,winrnd,right,tie,led_control,gameover}=%b required %b",
                         $time, dut_vec, exp_vec);
            end
        end
    end

    // ---------------- transaction log ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (clr)    $display("txn t=%0t clr pulse", $time);
            if (winrnd) $display("txn t=%0t winrnd right=%0b", $time, right);
            if (tie)    $display("txn t=%0t tie", $time);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic l, input logic r);
        pbl = l;
        pbr = r;
        @(negedge clk);
        pbl = 1'b0;
        pbr = 1'b0;
    endtask

    task automatic wait_arm(input string name);
        int n;
        n = 0;
        while (leds_on !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, leds_on}, 32'd1);
    endtask

    task automatic wait_clr(input string name);
        int n;
        n = 0;
        while (clr !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, clr}, 32'd1);
    endtask

    task automatic measure_arm(input string name);
        int edges;
        int extra_clr;
        edges = 1;
        extra_clr = 0;
        while (leds_on !== 1'b1 && edges < 1000) begin
            @(negedge clk);
            edges++;
            if (clr) extra_clr++;
        end
        // 4 + 8'hA5 = 169 WAIT cycles after the IDLE cycle -> armed on edge 170
        check(name, edges, 32'd170);
        check({name, "_single_clr"}, extra_clr, 32'd0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        tick(3);
        check("reset_outputs", {24'b0, dut_vec}, 32'd0);
        rst = 1'b0;

        // Round 1: delay from seed, right player wins, presses in HOLD ignored
        tick(1);
        check("clr_cycle1", {31'b0, clr}, 32'd1);
        measure_arm("arm_latency");
        tick(3);
        pulse(1'b0, 1'b1);
        check("win_right", {28'b0, winrnd, right, led_control}, 32'b1101);
        for (int i = 0; i < TB_HOLD; i++) begin
            @(negedge clk);
            pbl = (i == 1);
            check("hold_led", {29'b0, winrnd, led_control}, 32'b001);
        end
        pbl = 1'b0;
        tick(1);
        check("hold_exit_idle", {29'b0, clr, led_control}, 32'b000);
        tick(1);
        check("clr_after_hold", {31'b0, clr}, 32'd1);

        // Round 2: press during WAIT, then a simultaneous press when armed
        pulse(1'b1, 1'b0);
`ifdef TOW_FALSE_START_EN
        check("false_start_win", {30'b0, winrnd, right}, 32'b11);
        wait_clr("false_start_next_round");
`else
        check("wait_press_ignored", {28'b0, winrnd, leds_on, led_control}, 32'b0001);
`endif
        wait_arm("arm_round2");
        tick(1);
        pulse(1'b1, 1'b1);
        check("tie_pulse", {28'b0, tie, winrnd, led_control}, 32'b1000);
        tick(1);
        check("clr_after_tie", {30'b0, tie, clr}, 32'b01);

        // Round 3: left wins with rope at the end -> game over
        wait_arm("arm_round3");
        score = 7'b1000000;
        tick(2);
        pulse(1'b1, 1'b0);
        check("win_left", {30'b0, winrnd, right}, 32'b10);
        tick(TB_HOLD + 1);
        check("gameover_on", {29'b0, gameover, led_control}, 32'b111);
        tick(4);
        check("gameover_stays", {31'b0, gameover}, 32'd1);
        pulse(1'b1, 1'b0);
        check("gameover_exit", {28'b0, gameover, led_control, clr}, 32'b0000);
        score = CENTRE;
        tick(1);
        check("clr_after_gameover", {31'b0, clr}, 32'd1);

        // Round 4: asynchronous reset while armed
        wait_arm("arm_round4");
        tick(2);
        check("armed_before_rst", {31'b0, leds_on}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", {24'b0, dut_vec}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        check("clr_after_reset", {31'b0, clr}, 32'd1);
        measure_arm("arm_latency_after_reset");

        tick(3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

endmodule
